// File: rtl/bitonic_sort_ctrl.sv
// ============================================================================
// Module      : bitonic_sort_ctrl
// Description : In-place bitonic sorter driving a dual-port block RAM.
//               Walks the full bitonic network over 2^ADDR_BITS words,
//               reading each pair on ports A/B and writing swapped values
//               back through port A (the only write port).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitonic_sort_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_aen,
  output logic                 ram_ben,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addra,
  output logic [ADDR_BITS-1:0] ram_addrb,
  output logic [DATA_BITS-1:0] ram_dia,
  input  logic [DATA_BITS-1:0] ram_doa,
  input  logic [DATA_BITS-1:0] ram_dob
);

  // Width wide enough to hold the stage index ks = 1..ADDR_BITS
  localparam int KW = $clog2(ADDR_BITS + 1);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_RD   = 3'd1;
  localparam logic [2:0] c_CMP  = 3'd2;
  localparam logic [2:0] c_WR2  = 3'd3;
  localparam logic [2:0] c_FIN  = 3'd4;

  localparam logic [ADDR_BITS-2:0] c_P_LAST  = '1;
  localparam logic [KW-1:0]        c_KS_LAST = KW'(ADDR_BITS);

  logic [2:0]           r_state;
  logic [KW-1:0]        r_ks;
  logic [KW-1:0]        r_js;
  logic [ADDR_BITS-2:0] r_p;
  logic [DATA_BITS-1:0] r_hold_a;

  logic [ADDR_BITS-1:0] w_pext;
  logic [ADDR_BITS-1:0] w_jbit;
  logic [ADDR_BITS-1:0] w_mask;
  logic [ADDR_BITS-1:0] w_lo;
  logic [ADDR_BITS-1:0] w_hi;
  logic [ADDR_BITS:0]   w_kbit;
  logic                 w_asc;
  logic                 w_swap;
  logic                 w_p_last;
  logic                 w_js_zero;
  logic                 w_last;
  logic [ADDR_BITS-2:0] w_p_nxt;
  logic [KW-1:0]        w_js_nxt;
  logic [KW-1:0]        w_ks_nxt;

  // Pair addressing: insert a zero at bit js of p to form lo; hi sets that bit
  always_comb begin
    w_pext = {1'b0, r_p};
    w_jbit = ADDR_BITS'(1) << r_js;
    w_mask = w_jbit - ADDR_BITS'(1);
    w_lo   = ((w_pext & ~w_mask) << 1) | (w_pext & w_mask);
    w_hi   = w_lo | w_jbit;
    // k = 2^ks; in the final stage k lies above every address, so the pass is ascending
    w_kbit = (ADDR_BITS + 1)'(1) << r_ks;
    w_asc  = (r_ks == c_KS_LAST) || (({1'b0, w_lo} & w_kbit) == '0);
    w_swap = w_asc ? (ram_doa > ram_dob) : (ram_doa < ram_dob);
  end

  // Network counter advance: p innermost, then js downwards, then ks upwards
  always_comb begin
    w_p_last  = (r_p == c_P_LAST);
    w_js_zero = (r_js == '0);
    w_last    = (r_ks == c_KS_LAST) && w_js_zero && w_p_last;
    w_p_nxt   = r_p + (ADDR_BITS - 1)'(1);
    w_js_nxt  = r_js;
    w_ks_nxt  = r_ks;
    if (w_p_last) begin
      if (w_js_zero) begin
        w_ks_nxt = r_ks + KW'(1);
        w_js_nxt = r_ks;           // new ks - 1 equals old ks
      end else begin
        w_js_nxt = r_js - KW'(1);
      end
    end
  end

  // Sequencer state, network counters and the held port-A word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_ks     <= '0;
      r_js     <= '0;
      r_p      <= '0;
      r_hold_a <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state <= c_RD;
            r_ks    <= KW'(1);
            r_js    <= '0;
            r_p     <= '0;
          end
        end
        c_RD: begin
          r_state <= c_CMP;
        end
        c_CMP: begin
          if (w_swap) begin
            r_hold_a <= ram_doa;
            r_state  <= c_WR2;
          end else if (w_last) begin
            r_state <= c_FIN;
          end else begin
            r_state <= c_RD;
            r_p     <= w_p_nxt;
            r_js    <= w_js_nxt;
            r_ks    <= w_ks_nxt;
          end
        end
        c_WR2: begin
          if (w_last) begin
            r_state <= c_FIN;
          end else begin
            r_state <= c_RD;
            r_p     <= w_p_nxt;
            r_js    <= w_js_nxt;
            r_ks    <= w_ks_nxt;
          end
        end
        c_FIN: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // RAM pins and status decoded from state; reset forces IDLE so all drop to 0 at once
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    ram_aen   = 1'b0;
    ram_ben   = 1'b0;
    ram_we    = 1'b0;
    ram_addra = '0;
    ram_addrb = '0;
    ram_dia   = '0;
    case (r_state)
      c_RD: begin
        busy      = 1'b1;
        ram_aen   = 1'b1;
        ram_ben   = 1'b1;
        ram_addra = w_lo;
        ram_addrb = w_hi;
      end
      c_CMP: begin
        busy = 1'b1;
        if (w_swap) begin
          ram_we    = 1'b1;
          ram_aen   = 1'b1;
          ram_addra = w_lo;
          ram_dia   = ram_dob;
        end
      end
      c_WR2: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_aen   = 1'b1;
        ram_addra = w_hi;
        ram_dia   = r_hold_a;
      end
      c_FIN: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bitonic_sort_ctrl.sv
// ============================================================================
// Module      : tb_bitonic_sort_ctrl
// Description : Self-checking bench for bitonic_sort_ctrl with behavioural
//               RAM models and a textbook bitonic-network reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitonic_sort_ctrl;

  typedef logic [15:0] word_q_t[$];
  typedef int          int_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_clr = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // 8-word instance
  logic        s3_start = 1'b0;
  logic        s3_busy, s3_done, s3_aen, s3_ben, s3_we;
  logic [2:0]  s3_addra, s3_addrb;
  logic [15:0] s3_dia, s3_doa, s3_dob;
  logic [15:0] mem3 [8];
  logic [15:0] img3 [8];
  logic        ld3 = 1'b0;
  int          busy3, done3, we3, bad3;
  int_q_t      wq3;

  // 16-word instance
  logic        s4_start = 1'b0;
  logic        s4_busy, s4_done, s4_aen, s4_ben, s4_we;
  logic [3:0]  s4_addra, s4_addrb;
  logic [15:0] s4_dia, s4_doa, s4_dob;
  logic [15:0] mem4 [16];
  logic [15:0] img4 [16];
  logic        ld4 = 1'b0;
  int          busy4, done4, we4, bad4;
  int_q_t      wq4;

  word_q_t d, srt, snap;
  int_q_t  ws;
  int      sw;

  always #5 clk = ~clk;

  bitonic_sort_ctrl #(.ADDR_BITS(3), .DATA_BITS(16)) u3 (
    .clk(clk), .rst(rst), .start(s3_start), .busy(s3_busy), .done(s3_done),
    .ram_aen(s3_aen), .ram_ben(s3_ben), .ram_we(s3_we),
    .ram_addra(s3_addra), .ram_addrb(s3_addrb), .ram_dia(s3_dia),
    .ram_doa(s3_doa), .ram_dob(s3_dob)
  );

  bitonic_sort_ctrl #(.ADDR_BITS(4), .DATA_BITS(16)) u4 (
    .clk(clk), .rst(rst), .start(s4_start), .busy(s4_busy), .done(s4_done),
    .ram_aen(s4_aen), .ram_ben(s4_ben), .ram_we(s4_we),
    .ram_addra(s4_addra), .ram_addrb(s4_addrb), .ram_dia(s4_dia),
    .ram_doa(s4_doa), .ram_dob(s4_dob)
  );

  // Dual-port RAMs: registered read, port-A write, bulk image load
  always @(posedge clk) begin
    if (ld3) mem3 <= img3;
    else begin
      if (s3_aen) begin
        if (s3_we) mem3[s3_addra] <= s3_dia;
        s3_doa <= mem3[s3_addra];
      end
      if (s3_ben) s3_dob <= mem3[s3_addrb];
    end
    if (ld4) mem4 <= img4;
    else begin
      if (s4_aen) begin
        if (s4_we) mem4[s4_addra] <= s4_dia;
        s4_doa <= mem4[s4_addra];
      end
      if (s4_ben) s4_dob <= mem4[s4_addrb];
    end
  end

  // Activity monitors sampled mid-cycle
  always @(negedge clk) begin
    if (mon_clr) begin
      busy3 = 0; done3 = 0; we3 = 0; bad3 = 0; wq3.delete();
      busy4 = 0; done4 = 0; we4 = 0; bad4 = 0; wq4.delete();
    end else begin
      if (s3_busy) busy3++;
      if (s3_done) done3++;
      if (s3_we) begin we3++; wq3.push_back(int'(s3_addra)); end
      if ((s3_we || s3_aen || s3_ben) && !s3_busy) bad3++;
      if (s4_busy) busy4++;
      if (s4_done) done4++;
      if (s4_we) begin we4++; wq4.push_back(int'(s4_addra)); end
      if ((s4_we || s4_aen || s4_ben) && !s4_busy) bad4++;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Textbook bitonic network: k doubles, j halves, partner = i ^ j
  task automatic model(input int ab, input word_q_t din, output int swaps, output int_q_t wseq);
    word_q_t a;
    int n;
    logic [15:0] t;
    a = din;
    n = 1 << ab;
    swaps = 0;
    wseq = {};
    for (int k = 2; k <= n; k = k * 2)
      for (int j = k / 2; j >= 1; j = j / 2)
        for (int i = 0; i < n; i++) begin
          int l;
          bit asc;
          l = i ^ j;
          asc = ((i & k) == 0);
          if (l > i && ((asc && a[i] > a[l]) || (!asc && a[i] < a[l]))) begin
            t = a[i]; a[i] = a[l]; a[l] = t;
            swaps++;
            wseq.push_back(i);
            wseq.push_back(l);
          end
        end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic load3(input word_q_t v);
    for (int i = 0; i < 8; i++) img3[i] = v[i];
    ld3 = 1'b1;
    @(negedge clk); #1;
    ld3 = 1'b0;
  endtask

  task automatic load4(input word_q_t v);
    for (int i = 0; i < 16; i++) img4[i] = v[i];
    ld4 = 1'b1;
    @(negedge clk); #1;
    ld4 = 1'b0;
  endtask

  task automatic pulse3();
    s3_start = 1'b1;
    @(negedge clk); #1;
    s3_start = 1'b0;
  endtask

  task automatic pulse4();
    s4_start = 1'b1;
    @(negedge clk); #1;
    s4_start = 1'b0;
  endtask

  task automatic wait_done3(input string tag);
    int t = 0;
    while (done3 == 0 && t < 3000) begin @(negedge clk); #1; t++; end
    chk({tag, "_timeout"}, longint'(t < 3000), 1);
    repeat (3) begin @(negedge clk); #1; end
  endtask

  task automatic wait_done4(input string tag);
    int t = 0;
    while (done4 == 0 && t < 3000) begin @(negedge clk); #1; t++; end
    chk({tag, "_timeout"}, longint'(t < 3000), 1);
    repeat (3) begin @(negedge clk); #1; end
  endtask

  task automatic rand16(output word_q_t v);
    v = {};
    for (int i = 0; i < 16; i++) v.push_back(16'($urandom));
  endtask

  initial begin
    bit found;
    bit prev_we;
    bit hit;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", s3_busy, 0);
    chk("rst_done", s3_done, 0);
    chk("rst_en", {s3_aen, s3_ben, s3_we}, 0);
    chk("rst_addr", {s3_addra, s3_addrb}, 0);
    chk("rst_dia", s3_dia, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    // All words equal: no swaps, no writes
    d = {};
    for (int i = 0; i < 8; i++) d.push_back(16'h0005);
    load3(d);
    clear_mon();
    pulse3();
    wait_done3("eq");
    chk("eq_busy", busy3, 48);
    chk("eq_we", we3, 0);
    chk("eq_done", done3, 1);
    chk("eq_idle_en", bad3, 0);
    for (int i = 0; i < 8; i++) chk("eq_ram", mem3[i], 16'h0005);

    // Ascending input
    d = {};
    for (int i = 0; i < 8; i++) d.push_back(16'(i));
    model(3, d, sw, ws);
    load3(d);
    clear_mon();
    pulse3();
    wait_done3("asc");
    chk("asc_busy", busy3, 48 + sw);
    chk("asc_we", we3, 2 * sw);
    chk("asc_done", done3, 1);
    for (int i = 0; i < 8; i++) chk("asc_ram", mem3[i], i);

    // Descending input: write addresses follow the network lo-then-hi
    d = {};
    for (int i = 0; i < 8; i++) d.push_back(16'(7 - i));
    model(3, d, sw, ws);
    load3(d);
    clear_mon();
    pulse3();
    wait_done3("rev");
    chk("rev_busy", busy3, 48 + sw);
    chk("rev_idle_en", bad3, 0);
    for (int i = 0; i < 8; i++) chk("rev_ram", mem3[i], i);
    chk("rev_wlen", wq3.size(), ws.size());
    for (int i = 0; i < ws.size() && i < wq3.size(); i++) chk("rev_waddr", wq3[i], ws[i]);

    // 16 random words with extremes and a duplicate
    rand16(d);
    d[3] = 16'hFFFF; d[9] = 16'h0000; d[12] = 16'hFFFF;
    model(4, d, sw, ws);
    load4(d);
    clear_mon();
    pulse4();
    wait_done4("rnd");
    srt = d; srt.sort();
    chk("rnd_busy", busy4, 160 + sw);
    chk("rnd_done", done4, 1);
    chk("rnd_idle_en", bad4, 0);
    for (int i = 0; i < 16; i++) chk("rnd_ram", mem4[i], srt[i]);

    // Extra start pulses mid-sort are ignored
    rand16(d);
    model(4, d, sw, ws);
    load4(d);
    clear_mon();
    pulse4();
    repeat (20) @(negedge clk);
    #1;
    pulse4();
    repeat (40) @(negedge clk);
    #1;
    pulse4();
    wait_done4("mid");
    repeat (10) @(negedge clk);
    #1;
    srt = d; srt.sort();
    chk("mid_done", done4, 1);
    chk("mid_busy", busy4, 160 + sw);
    for (int i = 0; i < 16; i++) chk("mid_ram", mem4[i], srt[i]);

    // Reset during the second write cycle of a swap
    rand16(d);
    load4(d);
    clear_mon();
    pulse4();
    prev_we = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 1000 && !hit; t++) begin
      @(negedge clk); #1;
      if (s4_we && prev_we) hit = 1'b1;
      prev_we = s4_we;
    end
    chk("wr2_reached", hit, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", s4_busy, 0);
    chk("arst_done", s4_done, 0);
    chk("arst_en", {s4_aen, s4_ben, s4_we}, 0);
    chk("arst_addr", {s4_addra, s4_addrb}, 0);
    chk("arst_dia", s4_dia, 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    // The in-flight swap cannot complete, so only word values are checked here
    snap = {};
    for (int i = 0; i < 16; i++) begin
      found = 1'b0;
      for (int j = 0; j < 16; j++) if (d[j] == mem4[i]) found = 1'b1;
      chk("arst_member", found, 1);
      snap.push_back(mem4[i]);
    end
    model(4, snap, sw, ws);
    clear_mon();
    pulse4();
    wait_done4("resort");
    srt = snap; srt.sort();
    chk("resort_busy", busy4, 160 + sw);
    chk("resort_done", done4, 1);
    for (int i = 0; i < 16; i++) chk("resort_ram", mem4[i], srt[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
